// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combination lock controller.
package combo_lock_pkg;

  // Width of one BCD digit and number of digits per combination.
  localparam int unsigned DigitW    = 4;
  localparam int unsigned NumDigits = 4;
  localparam int unsigned CodeW     = DigitW * NumDigits;
  // Digit counter must hold 0..NumDigits.
  localparam int unsigned CntW      = $clog2(NumDigits + 1);

  // The enum values double as the LED encoding driven on state_o.
  typedef enum logic [2:0] {
    StLocked  = 3'd0,
    StEntry   = 3'd1,
    StCheck   = 3'd2,
    StOpen    = 3'd3,
    StProg    = 3'd4,
    StLockout = 3'd5
  } state_e;

  // Only 0..9 are legal keypad digits.
  function automatic logic digit_valid(input logic [DigitW-1:0] d);
    return d <= DigitW'(9);
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_lockout_timer.sv
// Lockout down-counter: start loads CYCLES-1, done while the count is zero.
module lockout_timer #(
  parameter int unsigned CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load on start, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CntW'(CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry, code check, programming and
// optional lockout. Define COMBO_LOCKOUT_EN to build the LOCKOUT state and
// its timer; without it every mismatch simply relocks and alarm is tied 0.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int unsigned      DIGITS         = 4,
  parameter logic [CodeW-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned      FAIL_LIMIT     = 3,
  parameter int unsigned      LOCKOUT_CYCLES = 500_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DigitW-1:0] digit_in,
  input  logic              enter_pulse,
  input  logic              clear_pulse,
  input  logic              lock_pulse,
  input  logic              prog_pulse,
  output logic              unlocked,
  output logic              alarm,
  output logic [CodeW-1:0]  disp_digits,
  output logic [3:0]        disp_blank,
  output logic [1:0]        fail_count,
  output logic [2:0]        state_o
);

  state_e           state_q, state_d;
  logic [CodeW-1:0] entry_q, entry_d;
  logic [CodeW-1:0] code_q, code_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       fail_q, fail_d;

  logic             enter_ok;
  logic             last_digit;
  logic [CodeW-1:0] shifted;
  logic [1:0]       fail_inc;

  assign enter_ok   = enter_pulse && digit_valid(digit_in);
  assign last_digit = (cnt_q == CntW'(DIGITS - 1));
  assign shifted    = {entry_q[CodeW-DigitW-1:0], digit_in};
  assign fail_inc   = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

`ifdef COMBO_LOCKOUT_EN
  logic timer_start;
  logic timer_done;

  lockout_timer #(
    .CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(timer_start),
    .done (timer_done)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{FAIL_LIMIT, LOCKOUT_CYCLES};
`endif

  // Next-state logic; only the pulses meaningful in each state compete,
  // in the order clear > lock > prog > enter.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
`ifdef COMBO_LOCKOUT_EN
    timer_start = 1'b0;
`endif
    unique case (state_q)
      StLocked: begin
        if (enter_ok) begin
          state_d = StEntry;
          entry_d = shifted;
          cnt_d   = CntW'(1);
        end
      end
      StEntry: begin
        if (clear_pulse) begin
          state_d = StLocked;
          entry_d = '0;
          cnt_d   = '0;
        end else if (enter_ok) begin
          entry_d = shifted;
          cnt_d   = cnt_q + CntW'(1);
          if (last_digit) state_d = StCheck;
        end
      end
      StCheck: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == code_q) begin
          state_d = StOpen;
          fail_d  = 2'd0;
        end else begin
          state_d = StLocked;
          fail_d  = fail_inc;
`ifdef COMBO_LOCKOUT_EN
          if (32'(fail_inc) == FAIL_LIMIT) begin
            state_d     = StLockout;
            timer_start = 1'b1;
          end
`endif
        end
      end
      StOpen: begin
        if (lock_pulse) begin
          state_d = StLocked;
        end else if (prog_pulse) begin
          state_d = StProg;
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      StProg: begin
        if (clear_pulse) begin
          state_d = StOpen;
          entry_d = '0;
          cnt_d   = '0;
        end else if (enter_ok) begin
          if (last_digit) begin
            state_d = StOpen;
            code_d  = shifted;
            entry_d = '0;
            cnt_d   = '0;
          end else begin
            entry_d = shifted;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
`ifdef COMBO_LOCKOUT_EN
      StLockout: begin
        if (timer_done) begin
          state_d = StLocked;
          fail_d  = 2'd0;
        end
      end
`endif
      default: state_d = StLocked;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StLocked;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      fail_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    unlocked    = (state_q == StOpen) || (state_q == StProg);
`ifdef COMBO_LOCKOUT_EN
    alarm       = (state_q == StLockout);
`else
    alarm       = 1'b0;
`endif
    state_o     = state_q;
    fail_count  = fail_q;
    disp_digits = '0;
    disp_blank  = 4'hF;
    if ((state_q == StEntry) || (state_q == StProg)) begin
      disp_digits = entry_q;
      for (int i = 0; i < NumDigits; i++) begin
        disp_blank[i] = (CntW'(i) >= cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: stimulus pushes every expected
// output change; a monitor pops one entry per observed change.
module tb_combo_lock_ctrl;
  import combo_lock_pkg::*;

  localparam int unsigned LC = 20;

  typedef struct packed {
    logic [2:0]  st;
    logic        unl;
    logic        alm;
    logic [1:0]  fc;
    logic [15:0] dd;
    logic [3:0]  db;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dur;  // cycles the previous output value lasted; 0 = don't care
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        enter_pulse = 1'b0;
  logic        clear_pulse = 1'b0;
  logic        lock_pulse = 1'b0;
  logic        prog_pulse = 1'b0;
  logic        unlocked;
  logic        alarm;
  logic [15:0] disp_digits;
  logic [3:0]  disp_blank;
  logic [1:0]  fail_count;
  logic [2:0]  state_o;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .DIGITS        (4),
    .DEFAULT_CODE  (16'h1234),
    .FAIL_LIMIT    (3),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_in   (digit_in),
    .enter_pulse(enter_pulse),
    .clear_pulse(clear_pulse),
    .lock_pulse (lock_pulse),
    .prog_pulse (prog_pulse),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .disp_digits(disp_digits),
    .disp_blank (disp_blank),
    .fail_count (fail_count),
    .state_o    (state_o)
  );

  function automatic snap_t mk(input state_e st, input logic [1:0] fc, input logic [15:0] dd,
                               input logic [3:0] db);
    snap_t s;
    s.st  = st;
    s.unl = (st == StOpen) || (st == StProg);
    s.alm = (st == StLockout);
    s.fc  = fc;
    s.dd  = dd;
    s.db  = db;
    return s;
  endfunction

  task automatic push(input snap_t s, input int dur);
    exp_t e;
    e.s   = s;
    e.dur = dur;
    q.push_back(e);
  endtask

  task automatic pulse(input logic e, input logic c, input logic l, input logic p,
                       input logic [3:0] d);
    @(negedge clk);
    enter_pulse = e;
    clear_pulse = c;
    lock_pulse  = l;
    prog_pulse  = p;
    digit_in    = d;
    @(negedge clk);
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    lock_pulse  = 1'b0;
    prog_pulse  = 1'b0;
    digit_in    = '0;
  endtask

  task automatic digit(input logic [3:0] d);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  // Four digits from LOCKED: three ENTRY displays, CHECK, then the outcome.
  task automatic entry(input logic [15:0] code, input logic [1:0] fc0, input state_e st_end,
                       input logic [1:0] fc1);
    logic [15:0] acc;
    logic [3:0]  b;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc = {acc[11:0], code[15-4*i -: 4]};
      b   = 4'hF << (i + 1);
      push(mk(StEntry, fc0, acc, b), 0);
    end
    push(mk(StCheck, fc0, 16'h0, 4'hF), 0);
    push(mk(st_end, fc1, 16'h0, 4'hF), 1);
    for (int i = 0; i < 4; i++) digit(code[15-4*i -: 4]);
  endtask

  // Four digits in PROG: three PROG displays, then back to OPEN.
  task automatic prog_code(input logic [15:0] code);
    logic [15:0] acc;
    logic [3:0]  b;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc = {acc[11:0], code[15-4*i -: 4]};
      b   = 4'hF << (i + 1);
      push(mk(StProg, 2'd0, acc, b), 0);
    end
    push(mk(StOpen, 2'd0, 16'h0, 4'hF), 0);
    for (int i = 0; i < 4; i++) digit(code[15-4*i -: 4]);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected output changes never seen, required 0 pending",
               q.size());
      q.delete();
    end
  endtask

  // Monitor: every change of the observable outputs consumes one expectation.
  initial begin
    snap_t cur, last;
    exp_t  e;
    int    cyc, last_cyc, dur, ev;
    last     = 'x;
    cyc      = 0;
    last_cyc = 0;
    ev       = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {state_o, unlocked, alarm, fail_count, disp_digits, disp_blank};
      if (cur !== last) begin
        ev++;
        checks++;
        dur = cyc - last_cyc;
        if (q.size() == 0) begin
          $display("FAIL event%0d: unexpected change to st=%0d unl=%b alm=%b fc=%0d disp=%h blank=%h, required no change",
                   ev, cur.st, cur.unl, cur.alm, cur.fc, cur.dd, cur.db);
        end else begin
          e = q.pop_front();
          if ((cur === e.s) && ((e.dur == 0) || (e.dur == dur))) begin
            passes++;
          end else begin
            $display("FAIL event%0d: got st=%0d unl=%b alm=%b fc=%0d disp=%h blank=%h dur=%0d, required st=%0d unl=%b alm=%b fc=%0d disp=%h blank=%h dur=%0d",
                     ev, cur.st, cur.unl, cur.alm, cur.fc, cur.dd, cur.db, dur,
                     e.s.st, e.s.unl, e.s.alm, e.s.fc, e.s.dd, e.s.db, e.dur);
          end
        end
        last     = cur;
        last_cyc = cyc;
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [1:0] fc_after_three;
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain();

    // Correct default code, then relock.
    entry(16'h1234, 2'd0, StOpen, 2'd0);
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    drain();

    // Wrong code.
    entry(16'h1235, 2'd0, StLocked, 2'd1);
    drain();

    // Partial entry aborted by clear.
    push(mk(StEntry, 2'd1, 16'h0001, 4'hE), 0);
    push(mk(StEntry, 2'd1, 16'h0012, 4'hC), 0);
    push(mk(StEntry, 2'd1, 16'h0123, 4'h8), 0);
    push(mk(StLocked, 2'd1, 16'h0, 4'hF), 0);
    digit(4'h1);
    digit(4'h2);
    digit(4'h3);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    drain();

    // Invalid digits ignored; clear beats a simultaneous enter.
    digit(4'hB);
    push(mk(StEntry, 2'd1, 16'h0007, 4'hE), 0);
    digit(4'h7);
    digit(4'hB);
    push(mk(StLocked, 2'd1, 16'h0, 4'hF), 0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    drain();

    // Match clears the failure count.
    entry(16'h1234, 2'd1, StOpen, 2'd0);
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    drain();

    // Three wrong codes.
    entry(16'h5555, 2'd0, StLocked, 2'd1);
    entry(16'h5555, 2'd1, StLocked, 2'd2);
`ifdef COMBO_LOCKOUT_EN
    entry(16'h5555, 2'd2, StLockout, 2'd3);
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), LC);
    repeat (3) digit(4'h1);
    fc_after_three = 2'd0;
`else
    entry(16'h5555, 2'd2, StLocked, 2'd3);
    entry(16'h5555, 2'd3, StLocked, 2'd3);
    fc_after_three = 2'd3;
`endif
    drain();

    // Reprogram to 9876 and confirm the old code no longer opens.
    entry(16'h1234, fc_after_three, StOpen, 2'd0);
    push(mk(StProg, 2'd0, 16'h0, 4'hF), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    prog_code(16'h9876);
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    entry(16'h1234, 2'd0, StLocked, 2'd1);
    entry(16'h9876, 2'd1, StOpen, 2'd0);
    drain();

    // Reset mid-PROG restores the default code.
    push(mk(StProg, 2'd0, 16'h0, 4'hF), 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    push(mk(StProg, 2'd0, 16'h0001, 4'hE), 0);
    push(mk(StProg, 2'd0, 16'h0012, 4'hC), 0);
    digit(4'h1);
    digit(4'h2);
    push(mk(StLocked, 2'd0, 16'h0, 4'hF), 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    entry(16'h1234, 2'd0, StOpen, 2'd0);
    drain();

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
